// File: rtl/scan_decoder.sv
// scan_decoder: registered binary-to-one-hot decoder with scan and sweep modes.
//
// Drives a one-hot output bus from a binary index. Besides direct decoding it can
// scan the active bit continuously up or down, or perform a single up-sweep
// across all outputs with a busy/done handshake. Each scanned output is held for
// DWELL clock cycles.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   enable_n  in   active-low enable; when high all outputs are forced off
//   mode      in   00 direct, 01 scan up, 10 scan down, 11 one-shot sweep
//   sel_in    in   binary select (direct) / start index (scan entry)
//   start     in   pulse launching a sweep from idle in mode 11
//   dec_out   out  registered one-hot output (or all zero)
//   cur_sel   out  binary index of the active dec_out bit
//   busy      out  high while a sweep is in progress
//   done      out  one-cycle pulse when a sweep completes
module scan_decoder #(
    parameter int unsigned SEL_WIDTH = 4,
    parameter int unsigned DWELL     = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_n,
    input  logic [1:0]                mode,
    input  logic [SEL_WIDTH-1:0]      sel_in,
    input  logic                      start,
    output logic [(1<<SEL_WIDTH)-1:0] dec_out,
    output logic [SEL_WIDTH-1:0]      cur_sel,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned          OUT_W    = 1 << SEL_WIDTH;
    localparam logic [SEL_WIDTH-1:0] SEL_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DWELL - 1);
    localparam logic [OUT_W-1:0]     ONE_HOT0 = OUT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StDirect,
        StScanUp,
        StScanDn,
        StSweep
    } state_e;

    state_e                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]       dec_q, dec_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   dec_on_d;
    logic                   enter;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dec_on_d = 1'b0;
        enter    = 1'b0;

        if (enable_n) begin
            // Disabled: drop to idle, keep the last index visible on cur_sel.
            state_d = StIdle;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle:   enter = 1'b1;
                StDirect: enter = 1'b1;
                StScanUp, StScanDn: begin
                    if ((state_q == StScanUp && mode == 2'b01) ||
                        (state_q == StScanDn && mode == 2'b10)) begin
                        dec_on_d = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            sel_d = (state_q == StScanUp) ? sel_q + 1'b1 : sel_q - 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        enter = 1'b1;
                    end
                end
                StSweep: begin
                    if (mode == 2'b11) begin
                        dec_on_d = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            if (sel_q == SEL_MAX) begin
                                // Final dwell finished: outputs off, pulse done.
                                state_d  = StIdle;
                                dec_on_d = 1'b0;
                                busy_d   = 1'b0;
                                done_d   = 1'b1;
                            end else begin
                                sel_d = sel_q + 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        enter = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            // Entry into the state selected by mode, with the counter cleared.
            if (enter) begin
                cnt_d  = '0;
                busy_d = 1'b0;
                unique case (mode)
                    2'b00: begin
                        state_d  = StDirect;
                        sel_d    = sel_in;
                        dec_on_d = 1'b1;
                    end
                    2'b01: begin
                        state_d  = StScanUp;
                        sel_d    = sel_in;
                        dec_on_d = 1'b1;
                    end
                    2'b10: begin
                        state_d  = StScanDn;
                        sel_d    = sel_in;
                        dec_on_d = 1'b1;
                    end
                    2'b11: begin
                        // A sweep only launches from idle; other states park in idle first.
                        if (state_q == StIdle && start) begin
                            state_d  = StSweep;
                            sel_d    = '0;
                            dec_on_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                    default: begin
                        state_d = StIdle;
                    end
                endcase
            end
        end

        // Output derived from the next index so dec_out always matches cur_sel.
        dec_d = dec_on_d ? (ONE_HOT0 << sel_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            cnt_q   <= '0;
            dec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dec_out = dec_q;
    assign cur_sel = sel_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed self-checking bench for scan_decoder (SEL_WIDTH=4, DWELL=2).
module tb_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic        enable_n;
    logic [1:0]  mode;
    logic [3:0]  sel_in;
    logic        start;
    logic [15:0] dec_out;
    logic [3:0]  cur_sel;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    scan_decoder #(
        .SEL_WIDTH (4),
        .DWELL     (2),
        .CNT_WIDTH (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_n (enable_n),
        .mode     (mode),
        .sel_in   (sel_in),
        .start    (start),
        .dec_out  (dec_out),
        .cur_sel  (cur_sel),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] d, input logic [3:0] s,
                           input logic b, input logic dn);
        chk({tag, ".dec"}, {16'h0, dec_out}, {16'h0, d});
        chk({tag, ".sel"}, {28'h0, cur_sel}, {28'h0, s});
        chk({tag, ".busy"}, {31'h0, busy}, {31'h0, b});
        chk({tag, ".done"}, {31'h0, done}, {31'h0, dn});
    endtask

    logic [15:0] up_exp [8];
    logic [15:0] dn_exp [6];
    int          done_seen;

    initial begin
        up_exp = '{16'h4000, 16'h4000, 16'h8000, 16'h8000,
                   16'h0001, 16'h0001, 16'h0002, 16'h0002};
        dn_exp = '{16'h0002, 16'h0002, 16'h0001, 16'h0001, 16'h8000, 16'h8000};

        // Reset and disabled hold
        rst_n = 1'b0; enable_n = 1'b1; mode = 2'b00; sel_in = 4'd5; start = 1'b0;
        #2;
        chk_all("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("disabled.dec", {16'h0, dec_out}, 32'h0);
        end

        // Direct decode of every index
        enable_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sel_in = 4'(i);
            start  = (i == 7);  // start outside mode 11 must be ignored
            tick();
            chk("direct.dec", {16'h0, dec_out}, 32'h1 << i);
            chk("direct.sel", {28'h0, cur_sel}, 32'(i));
            chk("direct.busy", {31'h0, busy}, 32'h0);
        end
        start = 1'b0;
        enable_n = 1'b1;
        tick();
        chk_all("disable", 16'h0000, 4'd15, 1'b0, 1'b0);

        // Scan up with wrap; sel_in changes after entry are ignored
        enable_n = 1'b0; mode = 2'b01; sel_in = 4'd14;
        for (int i = 0; i < 8; i++) begin
            tick();
            sel_in = 4'd3;
            chk("scan_up.dec", {16'h0, dec_out}, {16'h0, up_exp[i]});
        end
        chk("scan_up.sel", {28'h0, cur_sel}, 32'd1);

        // Scan down with wrap, entered by mode change
        mode = 2'b10; sel_in = 4'd1;
        for (int i = 0; i < 6; i++) begin
            tick();
            sel_in = 4'd9;
            chk("scan_dn.dec", {16'h0, dec_out}, {16'h0, dn_exp[i]});
        end
        chk("scan_dn.sel", {28'h0, cur_sel}, 32'd15);

        // Sweep: mode 11 parks in idle until start
        mode = 2'b11;
        tick();
        chk_all("sweep_wait", 16'h0000, 4'd15, 1'b0, 1'b0);
        tick();
        chk_all("sweep_wait2", 16'h0000, 4'd15, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        done_seen = 0;
        chk_all("sweep0", 16'h0001, 4'd0, 1'b1, 1'b0);
        for (int k = 1; k < 32; k++) begin
            start = (k == 10);  // restart attempt while busy
            tick();
            start = 1'b0;
            if (done) done_seen++;
            chk("sweep.dec", {16'h0, dec_out}, 32'h1 << (k / 2));
            chk("sweep.busy", {31'h0, busy}, 32'h1);
        end
        tick();
        if (done) done_seen++;
        chk_all("sweep_end", 16'h0000, 4'd15, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("sweep.done_count", 32'(done_seen), 32'd1);
        chk_all("sweep_after", 16'h0000, 4'd15, 1'b0, 1'b0);

        // Abort sweep by mode change at index 6
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) tick();
        chk_all("abort_mode_pre", 16'h0040, 4'd6, 1'b1, 1'b0);
        mode = 2'b00; sel_in = 4'd3;
        tick();
        chk_all("abort_mode", 16'h0008, 4'd3, 1'b0, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) done_seen++;
        end
        chk("abort_mode.no_done", 32'(done_seen), 32'd0);

        // Abort sweep by reset at index 6
        mode = 2'b11;
        tick();
        chk_all("rst_idle", 16'h0000, 4'd3, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) tick();
        chk_all("abort_rst_pre", 16'h0040, 4'd6, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("abort_rst", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        chk_all("abort_rst_hold", 16'h0000, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_all("post_rst_idle", 16'h0000, 4'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
